// File: rtl/sys_cmd_ctrl.sv
// sys_cmd_ctrl: decodes command frames from the UART receiver into
// register-file writes and reads and ALU operations, and queues the
// replies into the TX FIFO.
module sys_cmd_ctrl #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_W-1:0]     rx_p_data,
    input  logic                  rx_d_valid,
    output logic [ADDR_W-1:0]     rf_addr,
    output logic [DATA_W-1:0]     rf_wr_data,
    output logic                  rf_wr_en,
    output logic                  rf_rd_en,
    input  logic [DATA_W-1:0]     rf_rd_data,
    input  logic                  rf_rd_valid,
    output logic [3:0]            alu_fun,
    output logic                  alu_en,
    input  logic [2*DATA_W-1:0]   alu_out,
    input  logic                  alu_out_valid,
    output logic                  clk_gate_en,
    output logic [DATA_W-1:0]     fifo_wr_data,
    output logic                  fifo_wr_inc,
    input  logic                  fifo_full,
    output logic                  cmd_error
);

    localparam logic [DATA_W-1:0] CMD_WR  = DATA_W'(8'hAA);
    localparam logic [DATA_W-1:0] CMD_RD  = DATA_W'(8'hBB);
    localparam logic [DATA_W-1:0] CMD_ALU = DATA_W'(8'hCC);
    localparam logic [DATA_W-1:0] CMD_FUN = DATA_W'(8'hDD);

    typedef enum logic [3:0] {
        IDLE, WR_ADDR, WR_DATA, RD_ADDR, RD_WAIT,
        ALU_A, ALU_B, ALU_FUN, ALU_WAIT, SEND_LO, SEND_HI
    } state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   rf_addr_q, rf_addr_d;
    logic [DATA_W-1:0]   rf_wr_data_q, rf_wr_data_d;
    logic                rf_wr_en_q, rf_wr_en_d;
    logic                rf_rd_en_q, rf_rd_en_d;
    logic [3:0]          alu_fun_q, alu_fun_d;
    logic                alu_en_q, alu_en_d;
    logic                cmd_error_q, cmd_error_d;
    logic [2*DATA_W-1:0] res_q, res_d;   // reply payload (read byte or ALU result)
    logic                two_q, two_d;   // reply carries a high byte as well

    // State and registered-output update
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= IDLE;
            rf_addr_q    <= '0;
            rf_wr_data_q <= '0;
            rf_wr_en_q   <= 1'b0;
            rf_rd_en_q   <= 1'b0;
            alu_fun_q    <= '0;
            alu_en_q     <= 1'b0;
            cmd_error_q  <= 1'b0;
            res_q        <= '0;
            two_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            rf_addr_q    <= rf_addr_d;
            rf_wr_data_q <= rf_wr_data_d;
            rf_wr_en_q   <= rf_wr_en_d;
            rf_rd_en_q   <= rf_rd_en_d;
            alu_fun_q    <= alu_fun_d;
            alu_en_q     <= alu_en_d;
            cmd_error_q  <= cmd_error_d;
            res_q        <= res_d;
            two_q        <= two_d;
        end
    end

    // Frame decode: next state, latched fields and next-cycle strobes
    always_comb begin
        state_d      = state_q;
        rf_addr_d    = rf_addr_q;
        rf_wr_data_d = rf_wr_data_q;
        rf_wr_en_d   = 1'b0;
        rf_rd_en_d   = 1'b0;
        alu_fun_d    = alu_fun_q;
        alu_en_d     = 1'b0;
        cmd_error_d  = 1'b0;
        res_d        = res_q;
        two_d        = two_q;
        case (state_q)
            IDLE: if (rx_d_valid) begin
                if      (rx_p_data == CMD_WR)  state_d = WR_ADDR;
                else if (rx_p_data == CMD_RD)  state_d = RD_ADDR;
                else if (rx_p_data == CMD_ALU) state_d = ALU_A;
                else if (rx_p_data == CMD_FUN) state_d = ALU_FUN;
                else                           cmd_error_d = 1'b1;
            end
            WR_ADDR: if (rx_d_valid) begin
                rf_addr_d = rx_p_data[ADDR_W-1:0];
                state_d   = WR_DATA;
            end
            WR_DATA: if (rx_d_valid) begin
                rf_wr_data_d = rx_p_data;
                rf_wr_en_d   = 1'b1;
                state_d      = IDLE;
            end
            RD_ADDR: if (rx_d_valid) begin
                rf_addr_d  = rx_p_data[ADDR_W-1:0];
                rf_rd_en_d = 1'b1;
                state_d    = RD_WAIT;
            end
            RD_WAIT: if (rf_rd_valid) begin
                res_d   = {{DATA_W{1'b0}}, rf_rd_data};
                two_d   = 1'b0;
                state_d = SEND_LO;
            end
            ALU_A: if (rx_d_valid) begin
                rf_addr_d    = '0;
                rf_wr_data_d = rx_p_data;
                rf_wr_en_d   = 1'b1;
                state_d      = ALU_B;
            end
            ALU_B: if (rx_d_valid) begin
                rf_addr_d    = ADDR_W'(1);
                rf_wr_data_d = rx_p_data;
                rf_wr_en_d   = 1'b1;
                state_d      = ALU_FUN;
            end
            ALU_FUN: if (rx_d_valid) begin
                alu_fun_d = rx_p_data[3:0];
                alu_en_d  = 1'b1;
                state_d   = ALU_WAIT;
            end
            ALU_WAIT: if (alu_out_valid) begin
                res_d   = alu_out;
                two_d   = 1'b1;
                state_d = SEND_LO;
            end
            SEND_LO: if (!fifo_full) state_d = two_q ? SEND_HI : IDLE;
            SEND_HI: if (!fifo_full) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign rf_addr     = rf_addr_q;
    assign rf_wr_data  = rf_wr_data_q;
    assign rf_wr_en    = rf_wr_en_q;
    assign rf_rd_en    = rf_rd_en_q;
    assign alu_fun     = alu_fun_q;
    assign alu_en      = alu_en_q;
    assign cmd_error   = cmd_error_q;
    assign clk_gate_en = (state_q == ALU_FUN) || (state_q == ALU_WAIT);

    // The FIFO push is qualified with the live full flag so a write can
    // never land on a full FIFO; the byte stays parked in res_q meanwhile.
    assign fifo_wr_inc  = ((state_q == SEND_LO) || (state_q == SEND_HI)) && !fifo_full;
    assign fifo_wr_data = (state_q == SEND_HI) ? res_q[2*DATA_W-1:DATA_W] : res_q[DATA_W-1:0];

endmodule

// File: tb/tb_sys_cmd_ctrl.sv
// Bench for sys_cmd_ctrl: transaction-level scoreboard plus a register-file
// and ALU responder, directed frames first, then randomized frames with
// random FIFO backpressure.
module tb_sys_cmd_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [7:0]  rx_p_data = '0;
    logic        rx_d_valid = 1'b0;
    logic [3:0]  rf_addr;
    logic [7:0]  rf_wr_data;
    logic        rf_wr_en, rf_rd_en;
    logic [7:0]  rf_rd_data = '0;
    logic        rf_rd_valid = 1'b0;
    logic [3:0]  alu_fun;
    logic        alu_en;
    logic [15:0] alu_out = '0;
    logic        alu_out_valid = 1'b0;
    logic        clk_gate_en;
    logic [7:0]  fifo_wr_data;
    logic        fifo_wr_inc;
    logic        fifo_full = 1'b0;
    logic        cmd_error;

    sys_cmd_ctrl #(.DATA_W(8), .ADDR_W(4)) dut (
        .clk(clk), .rst(rst),
        .rx_p_data(rx_p_data), .rx_d_valid(rx_d_valid),
        .rf_addr(rf_addr), .rf_wr_data(rf_wr_data), .rf_wr_en(rf_wr_en), .rf_rd_en(rf_rd_en),
        .rf_rd_data(rf_rd_data), .rf_rd_valid(rf_rd_valid),
        .alu_fun(alu_fun), .alu_en(alu_en), .alu_out(alu_out), .alu_out_valid(alu_out_valid),
        .clk_gate_en(clk_gate_en),
        .fifo_wr_data(fifo_wr_data), .fifo_wr_inc(fifo_wr_inc), .fifo_full(fifo_full),
        .cmd_error(cmd_error)
    );

    always #5 clk = ~clk;

    int n_chk = 0, n_fail = 0;

    // scoreboard state
    logic [11:0] exp_wr[$];
    logic [3:0]  exp_rd[$];
    logic [3:0]  exp_alu[$];
    logic [7:0]  exp_fifo[$];
    int          exp_err = 0;
    logic [7:0]  model_rf[16];
    logic [7:0]  env_rf[16];

    // observations used by the literal checks
    int          obs_wr = 0, obs_fifo = 0, obs_err = 0;
    logic [3:0]  last_wr_a;
    logic [7:0]  last_wr_d;
    logic [3:0]  last_fun;
    logic [7:0]  fifo_hist[$];

    logic gate_mark = 1'b0;
    logic gate_exp;
    bit   bp_en = 1'b0;

    task automatic check(input string name, input bit ok, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (!ok) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [15:0] alu_model(input logic [7:0] a, input logic [7:0] b, input logic [3:0] f);
        case (f)
            4'd0:    return {8'h00, a} + {8'h00, b};
            4'd1:    return {8'h00, a} - {8'h00, b};
            4'd2:    return {8'h00, a} * {8'h00, b};
            4'd3:    return {8'h00, a & b};
            4'd4:    return {8'h00, a | b};
            default: return {a, a ^ b};
        endcase
    endfunction

    // clock gate must be on from the byte that enters the function phase
    // until the ALU result comes back
    always @(posedge clk or negedge rst) begin
        if (!rst) gate_exp <= 1'b0;
        else if (rx_d_valid && gate_mark) gate_exp <= 1'b1;
        else if (alu_out_valid) gate_exp <= 1'b0;
    end

    // compare process
    bit prev_rdv = 0, prev_aluv = 0;
    always @(negedge clk) begin
        if (rst) begin
            int ns;
            ns = int'(rf_wr_en) + int'(rf_rd_en) + int'(alu_en) + int'(fifo_wr_inc) + int'(cmd_error);
            check("strobe_exclusive", ns <= 1, ns, 1);
            if (fifo_full) check("no_push_when_full", fifo_wr_inc == 1'b0, fifo_wr_inc, 0);
            if ((prev_rdv || prev_aluv) && !fifo_full)
                check("reply_latency", fifo_wr_inc == 1'b1, fifo_wr_inc, 1);
            check("clk_gate_en", clk_gate_en == gate_exp, clk_gate_en, gate_exp);
            if (rf_wr_en) begin
                obs_wr++; last_wr_a = rf_addr; last_wr_d = rf_wr_data;
                if (exp_wr.size() == 0) check("rf_wr_unexpected", 0, {rf_addr, rf_wr_data}, 0);
                else begin
                    logic [11:0] e;
                    e = exp_wr.pop_front();
                    check("rf_wr", {rf_addr, rf_wr_data} == e, {rf_addr, rf_wr_data}, e);
                end
            end
            if (rf_rd_en) begin
                if (exp_rd.size() == 0) check("rf_rd_unexpected", 0, rf_addr, 0);
                else begin
                    logic [3:0] e;
                    e = exp_rd.pop_front();
                    check("rf_rd_addr", rf_addr == e, rf_addr, e);
                end
            end
            if (alu_en) begin
                last_fun = alu_fun;
                if (exp_alu.size() == 0) check("alu_en_unexpected", 0, alu_fun, 0);
                else begin
                    logic [3:0] e;
                    e = exp_alu.pop_front();
                    check("alu_fun", alu_fun == e, alu_fun, e);
                end
            end
            if (fifo_wr_inc) begin
                obs_fifo++; fifo_hist.push_back(fifo_wr_data);
                if (exp_fifo.size() == 0) check("fifo_unexpected", 0, fifo_wr_data, 0);
                else begin
                    logic [7:0] e;
                    e = exp_fifo.pop_front();
                    check("fifo_data", fifo_wr_data == e, fifo_wr_data, e);
                end
            end
            if (cmd_error) begin
                obs_err++;
                check("cmd_error_expected", exp_err > 0, 1, exp_err);
                if (exp_err > 0) exp_err--;
            end
            prev_rdv  = rf_rd_valid;
            prev_aluv = alu_out_valid;
        end else begin
            prev_rdv  = 0;
            prev_aluv = 0;
        end
    end

    // register-file and ALU responder (random 1..3 cycle return latency)
    initial begin
        int rd_cnt, alu_cnt;
        logic [3:0] rd_a, alu_f;
        rd_cnt = 0; alu_cnt = 0; rd_a = '0; alu_f = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                if (rf_wr_en) env_rf[rf_addr] = rf_wr_data;
                if (rf_rd_en) begin rd_cnt = $urandom_range(1, 3); rd_a = rf_addr; end
                if (alu_en) begin alu_cnt = $urandom_range(1, 3); alu_f = alu_fun; end
            end else begin
                rd_cnt = 0; alu_cnt = 0;
            end
            @(posedge clk); #1;
            rf_rd_valid = 1'b0;
            alu_out_valid = 1'b0;
            if (rd_cnt > 0) begin
                rd_cnt--;
                if (rd_cnt == 0) begin rf_rd_valid = 1'b1; rf_rd_data = env_rf[rd_a]; end
            end
            if (alu_cnt > 0) begin
                alu_cnt--;
                if (alu_cnt == 0) begin alu_out_valid = 1'b1; alu_out = alu_model(env_rf[0], env_rf[1], alu_f); end
            end
        end
    end

    // random backpressure
    initial forever begin
        @(posedge clk); #1;
        if (bp_en) fifo_full = ($urandom_range(0, 3) == 0);
    end

    // driver tasks: all called at posedge+1
    task automatic send_byte(input logic [7:0] b, input bit gm);
        rx_p_data = b; rx_d_valid = 1'b1; gate_mark = gm;
        @(posedge clk); #1;
        rx_d_valid = 1'b0; gate_mark = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic wait_done(input string name);
        int i;
        for (i = 0; i < 300; i++) begin
            if (exp_wr.size() == 0 && exp_rd.size() == 0 && exp_alu.size() == 0 &&
                exp_fifo.size() == 0 && exp_err == 0) break;
            @(posedge clk); #1;
        end
        check({name, "_timeout"}, i < 300, i, 300);
        exp_wr.delete(); exp_rd.delete(); exp_alu.delete(); exp_fifo.delete(); exp_err = 0;
    endtask

    task automatic do_write(input logic [3:0] a, input logic [7:0] d);
        logic [7:0] ab;
        ab = {4'($urandom_range(0, 15)), a};
        exp_wr.push_back({a, d});
        model_rf[a] = d;
        send_byte(8'hAA, 0); send_byte(ab, 0); send_byte(d, 0);
    endtask

    task automatic do_read(input logic [3:0] a, input bit junk);
        logic [7:0] ab;
        ab = {4'($urandom_range(0, 15)), a};
        exp_rd.push_back(a);
        exp_fifo.push_back(model_rf[a]);
        send_byte(8'hBB, 0); send_byte(ab, 0);
        if (junk) send_byte(8'($urandom_range(0, 255)), 0);
    endtask

    task automatic do_alu(input bit with_ops, input logic [7:0] x, input logic [7:0] y,
                          input logic [3:0] f, input bit junk);
        logic [15:0] r;
        logic [7:0]  fb;
        fb = {4'($urandom_range(0, 15)), f};
        if (with_ops) begin
            exp_wr.push_back({4'd0, x}); exp_wr.push_back({4'd1, y});
            model_rf[0] = x; model_rf[1] = y;
        end
        exp_alu.push_back(f);
        r = alu_model(model_rf[0], model_rf[1], f);
        exp_fifo.push_back(r[7:0]); exp_fifo.push_back(r[15:8]);
        if (with_ops) begin send_byte(8'hCC, 0); send_byte(x, 0); send_byte(y, 1); end
        else send_byte(8'hDD, 1);
        send_byte(fb, 0);
        if (junk) send_byte(8'($urandom_range(0, 255)), 0);
    endtask

    initial begin
        int wr0, i;
        for (int k = 0; k < 16; k++) begin model_rf[k] = '0; env_rf[k] = '0; end

        // reset state
        repeat (2) @(negedge clk);
        check("reset_strobes", {rf_wr_en, rf_rd_en, alu_en, fifo_wr_inc, cmd_error, clk_gate_en} == 6'b0,
              {rf_wr_en, rf_rd_en, alu_en, fifo_wr_inc, cmd_error, clk_gate_en}, 0);
        check("reset_regs", {rf_addr, rf_wr_data, alu_fun, fifo_wr_data} == 24'h0,
              {rf_addr, rf_wr_data, alu_fun, fifo_wr_data}, 0);
        @(posedge clk); #1; rst = 1'b1;
        idle(1);

        // single write
        do_write(4'h5, 8'h3C);
        check("wr_latency", rf_wr_en == 1'b1, rf_wr_en, 1);
        wait_done("write");
        check("wr_count", obs_wr == 1, obs_wr, 1);
        check("wr_addr_lit", last_wr_a == 4'h5, last_wr_a, 5);
        check("wr_data_lit", last_wr_d == 8'h3C, last_wr_d, 8'h3C);
        check("wr_no_fifo", obs_fifo == 0, obs_fifo, 0);

        // read returns one byte
        do_write(4'h2, 8'h7E); wait_done("write2");
        do_read(4'h2, 0); wait_done("read");
        check("rd_fifo_count", obs_fifo == 1, obs_fifo, 1);
        check("rd_fifo_lit", fifo_hist[fifo_hist.size()-1] == 8'h7E, fifo_hist[fifo_hist.size()-1], 8'h7E);

        // ALU frame with operands
        do_alu(1, 8'h10, 8'h20, 4'h0, 0); wait_done("alu");
        check("alu_fifo_count", obs_fifo == 3, obs_fifo, 3);
        check("alu_lo_lit", fifo_hist[1] == 8'h30, fifo_hist[1], 8'h30);
        check("alu_hi_lit", fifo_hist[2] == 8'h00, fifo_hist[2], 8'h00);
        check("alu_fun_lit", last_fun == 4'h0, last_fun, 0);
        idle(1);
        check("gate_off_after", clk_gate_en == 1'b0, clk_gate_en, 0);

        // backpressure during ALU reply
        fifo_full = 1'b1;
        do_alu(1, 8'h10, 8'h20, 4'h0, 0);
        for (i = 0; i < 50 && !alu_out_valid; i++) @(negedge clk);
        check("bp_alu_timeout", i < 50, i, 50);
        repeat (5) begin
            @(negedge clk);
            check("bp_data_held", fifo_wr_data == 8'h30, fifo_wr_data, 8'h30);
            check("bp_no_push", fifo_wr_inc == 1'b0, fifo_wr_inc, 0);
        end
        @(posedge clk); #1; fifo_full = 1'b0;
        wait_done("bp");
        check("bp_order_lo", fifo_hist[3] == 8'h30, fifo_hist[3], 8'h30);
        check("bp_order_hi", fifo_hist[4] == 8'h00, fifo_hist[4], 8'h00);

        // bad command byte
        exp_err++;
        send_byte(8'h55, 0); wait_done("err");
        check("err_count", obs_err == 1, obs_err, 1);

        // reset mid-frame: the aborted write must never happen
        wr0 = obs_wr;
        send_byte(8'hAA, 0); send_byte(8'h05, 0);
        rst = 1'b0;
        @(negedge clk);
        check("midreset_regs", {rf_addr, rf_wr_en, clk_gate_en} == 6'b0, {rf_addr, rf_wr_en, clk_gate_en}, 0);
        idle(2); rst = 1'b1; idle(1);
        do_read(4'h5, 0); wait_done("post_reset_read");
        check("midreset_no_wr", obs_wr == wr0, obs_wr, wr0);
        check("post_reset_rd_lit", fifo_hist[fifo_hist.size()-1] == 8'h3C, fifo_hist[fifo_hist.size()-1], 8'h3C);

        // randomized frames with backpressure and dropped bytes
        bp_en = 1'b1;
        for (int n = 0; n < 250; n++) begin
            int kind;
            logic [7:0] b;
            kind = $urandom_range(0, 4);
            case (kind)
                0: do_write(4'($urandom_range(0, 15)), 8'($urandom_range(0, 255)));
                1: do_read(4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)));
                2: do_alu(1, 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
                          4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)));
                3: do_alu(0, 8'h00, 8'h00, 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)));
                default: begin
                    do b = 8'($urandom_range(0, 255));
                    while (b == 8'hAA || b == 8'hBB || b == 8'hCC || b == 8'hDD);
                    exp_err++;
                    send_byte(b, 0);
                end
            endcase
            wait_done("random");
            idle($urandom_range(0, 2));
        end
        bp_en = 1'b0;
        idle(1); fifo_full = 1'b0; idle(3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/sys_cmd_ctrl.md
SYS_CMD_CTRL -- requirements
Module: sys_cmd_ctrl

Interface
REQ-001 SHALL have parameter DATA_W, default 8, byte width of received frames, register data and FIFO data.
REQ-002 SHALL have parameter ADDR_W, default 4, register-file address width.
REQ-003 SHALL have port clk  input  1  single system clock; all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous and active-low.
REQ-005 SHALL have port rx_p_data  input  DATA_W  byte received by UART_RX, already synchronized to clk.
REQ-006 SHALL have port rx_d_valid  input  1  one-cycle pulse, rx_p_data valid.
REQ-007 SHALL have ports rf_addr output ADDR_W; rf_wr_data output DATA_W; rf_wr_en output 1; rf_rd_en output 1: register-file access.
REQ-008 SHALL have ports rf_rd_data input DATA_W; rf_rd_valid input 1: read return.
REQ-009 SHALL have ports alu_fun output 4; alu_en output 1; alu_out input 2*DATA_W; alu_out_valid input 1: ALU control and result.
REQ-010 SHALL have port clk_gate_en  output  1  ALU clock-gate enable.
REQ-011 SHALL have ports fifo_wr_data output DATA_W; fifo_wr_inc output 1; fifo_full input 1: TX FIFO write side.
REQ-012 SHALL have port cmd_error  output  1  one-cycle pulse on an unrecognized command byte.

Function
REQ-013 SHALL be a Moore FSM with states IDLE, WR_ADDR, WR_DATA, RD_ADDR, RD_WAIT, ALU_A, ALU_B, ALU_FUN, ALU_WAIT, SEND_LO, SEND_HI; a byte is consumed only on a cycle with rx_d_valid=1.
REQ-014 IDLE: byte 0xAA -> WR_ADDR; 0xBB -> RD_ADDR; 0xCC -> ALU_A; 0xDD -> ALU_FUN; any other byte -> cmd_error=1 for that cycle, stay IDLE.
REQ-015 WR_ADDR: latch rx_p_data[ADDR_W-1:0] as address -> WR_DATA; WR_DATA: on byte assert rf_wr_en=1 for exactly one cycle with latched rf_addr and rf_wr_data=byte, then -> IDLE.
REQ-016 RD_ADDR: on byte latch address, assert rf_rd_en=1 for one cycle -> RD_WAIT; RD_WAIT: on rf_rd_valid latch rf_rd_data -> SEND_LO (single-byte reply).
REQ-017 ALU_A: on byte write it to rf address 0 (one-cycle rf_wr_en) -> ALU_B; ALU_B: write byte to rf address 1 -> ALU_FUN.
REQ-018 ALU_FUN: on byte latch alu_fun=byte[3:0], assert alu_en=1 for one cycle -> ALU_WAIT; clk_gate_en SHALL be 1 in ALU_FUN and ALU_WAIT only, 0 elsewhere.
REQ-019 ALU_WAIT: on alu_out_valid latch alu_out -> SEND_LO (two-byte reply).
REQ-020 SEND_LO: when fifo_full=0, fifo_wr_inc=1 for one cycle with fifo_wr_data=low byte; -> SEND_HI for ALU reply, else -> IDLE. SEND_HI: same with high byte, then -> IDLE.
REQ-021 fifo_wr_inc SHALL never be 1 while fifo_full=1; controller SHALL hold in SEND_LO/SEND_HI, data stable, until fifo_full=0.
REQ-022 rx_d_valid arriving in RD_WAIT, ALU_WAIT, SEND_LO or SEND_HI SHALL be ignored (byte dropped, no error).
REQ-023 Strobes rf_wr_en, rf_rd_en, alu_en, fifo_wr_inc, cmd_error SHALL be registered, one cycle wide, never asserted in the same cycle as each other.
REQ-024 Latency: rf_wr_en rises the cycle after the data byte's rx_d_valid; fifo_wr_inc for read rises one cycle after rf_rd_valid when FIFO not full.

Reset
REQ-025 On rst=0, asynchronously: state=IDLE, all strobes 0, clk_gate_en=0, rf_addr, rf_wr_data, alu_fun, fifo_wr_data and internal result registers = 0.
REQ-026 Reset mid-frame SHALL abort the frame with no further writes; first byte after release is decoded as a command.

Verification
REQ-027 Write: bytes 0xAA,0x05,0x3C -> one rf_wr_en pulse, rf_addr=5, rf_wr_data=0x3C; no FIFO write.
REQ-028 Read: 0xBB,0x02, rf_rd_data=0x7E with rf_rd_valid -> exactly one fifo_wr_inc, fifo_wr_data=0x7E.
REQ-029 ALU: 0xCC,0x10,0x20,0x00, alu_out=0x0030 -> rf writes addr0=0x10, addr1=0x20, alu_en pulse with alu_fun=0, FIFO writes 0x30 then 0x00, clk_gate_en low after.
REQ-030 Backpressure: fifo_full=1 for 5 cycles during ALU reply -> no fifo_wr_inc while full, data held, both bytes written in order after release.
REQ-031 Error/reset: byte 0x55 in IDLE -> cmd_error pulse, state IDLE; rst=0 after 0xAA,0x05 -> no rf_wr_en, next 0xBB decoded as read.
